gate_sweep_ctrl: RTL and testbench

- Self-test sequencer for the two-input `basic_gate` block.
- On `start`, it drives `basic_gate` inputs a,b through 00, 01, 10, 11 in that order.
- For each vector it waits a programmable settle time, captures the seven gate outputs and compares them with the golden truth table.
- It reports per-vector errors and an overall pass flag, and sits beside `basic_gate` as its stimulus/checker controller.

---
 rtl/gate_sweep_ctrl_pkg.sv | 40 ++++
 rtl/gate_settle_timer.sv | 31 +++
 rtl/gate_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_gate_sweep_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_ctrl_pkg.sv
// rtl/gate_sweep_ctrl_pkg.sv - shared states, golden table and y-bit map for the basic_gate sweep
package gate_sweep_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Bit positions of each gate function inside gate_y, kept here for later checkers
  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_NAND = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_XOR  = 4;
  localparam int Y_XNOR = 5;
  localparam int Y_NOTA = 6;

  // Golden gate_y for each {a,b} input vector
  localparam logic [6:0] EXP0 = 7'h6C;
  localparam logic [6:0] EXP1 = 7'h56;
  localparam logic [6:0] EXP2 = 7'h16;
  localparam logic [6:0] EXP3 = 7'h23;

  // Golden lookup by vector index
  function automatic logic [6:0] exp_for(input logic [1:0] idx);
    logic [6:0] r;
    case (idx)
      2'd0:    r = EXP0;
      2'd1:    r = EXP1;
      2'd2:    r = EXP2;
      default: r = EXP3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// rtl/gate_settle_timer.sv - settle counter: load to zero, count while enabled, flag the last wait cycle
module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Count value seen during the final wait cycle; unused when there is no wait at all
  localparam logic [CNT_W-1:0] LAST = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  // Counter: load has priority, otherwise advance while the sequencer waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - stimulus/checker sequencer sweeping basic_gate through all four input vectors
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic [6:0] gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  input  logic [1:0] rd_idx,
  output logic [6:0] rd_data
);

  import gate_sweep_ctrl_pkg::*;

  localparam bit HAS_WAIT = (SETTLE_CYCLES > 0);

  state_t     state;
  logic [1:0] idx;
  logic [6:0] capture [4];
  logic       timer_expired;
  logic       mismatch;
  logic [3:0] mask_upd;

  gate_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == S_APPLY),
    .en      (state == S_WAIT),
    .expired (timer_expired)
  );

  // Golden compare of the current vector and the error mask it would produce
  always_comb begin
    mismatch      = (gate_y != exp_for(idx));
    mask_upd      = err_mask;
    mask_upd[idx] = mismatch;
  end

  // Sequencer: walks the four vectors, captures results, reports done/pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= 4'd0;
      for (int i = 0; i < 4; i++) capture[i] <= 7'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state    <= S_APPLY;
            busy     <= 1'b1;
            idx      <= 2'd0;
            err_mask <= 4'd0;
            pass     <= 1'b0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
          end
        end
        S_APPLY, S_WAIT, S_SAMPLE: begin
          if (abort) begin
            // Partial captures and err_mask are left intact for inspection
            state  <= S_IDLE;
            busy   <= 1'b0;
            pass   <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else if (state == S_APPLY) begin
            state <= HAS_WAIT ? S_WAIT : S_SAMPLE;
          end else if (state == S_WAIT) begin
            if (timer_expired) state <= S_SAMPLE;
          end else begin
            capture[idx] <= gate_y;
            err_mask     <= mask_upd;
            if (idx == 2'd3) begin
              state <= S_FINISH;
              done  <= 1'b1;
              pass  <= (mask_upd == 4'd0);
            end else begin
              idx              <= idx + 2'd1;
              {gate_a, gate_b} <= idx + 2'd1;
              state            <= S_APPLY;
            end
          end
        end
        S_FINISH: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          gate_a <= 1'b0;
          gate_b <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = capture[rd_idx];

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - scoreboard bench for gate_sweep_ctrl with a behavioural basic_gate
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, start0, abort0;
  logic [1:0] rd_idx, rd_idx0;
  logic [6:0] fault;

  logic       gate_a, gate_b, busy, done, pass;
  logic [3:0] err_mask;
  logic [6:0] rd_data, gate_y;

  logic       gate_a0, gate_b0, busy0, done0, pass0;
  logic [3:0] err_mask0;
  logic [6:0] rd_data0, gate_y0;

  // {NOT a, XNOR, XOR, NOR, NAND, OR, AND}
  function automatic logic [6:0] gate_model(input logic a, input logic b);
    return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  assign gate_y  = gate_model(gate_a, gate_b) & ~fault;
  assign gate_y0 = gate_model(gate_a0, gate_b0);

  gate_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
    .busy(busy), .done(done), .pass(pass), .err_mask(err_mask),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gate_a(gate_a0), .gate_b(gate_b0), .gate_y(gate_y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_mask(err_mask0),
    .rd_idx(rd_idx0), .rd_data(rd_data0)
  );

  typedef struct {
    int         cyc;
    logic       pass;
    logic [3:0] mask;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] golden [4];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) check("dut unexpected done", done, 0);
      else begin
        e = q.pop_front();
        check("dut done cycle", cyc, e.cyc);
        check("dut done pass", pass, e.pass);
        check("dut done err_mask", err_mask, e.mask);
      end
    end
    if (rst_n && done0) begin
      if (q0.size() == 0) check("dut0 unexpected done", done0, 0);
      else begin
        e = q0.pop_front();
        check("dut0 done cycle", cyc, e.cyc);
        check("dut0 done pass", pass0, e.pass);
        check("dut0 done err_mask", err_mask0, e.mask);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    golden[0] = 7'h6C; golden[1] = 7'h56; golden[2] = 7'h16; golden[3] = 7'h23;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    rd_idx = 2'd0; rd_idx0 = 2'd0; fault = 7'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset ab", {gate_a, gate_b}, 0);
    check("reset err_mask", err_mask, 0);
    check("reset rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal sweep, done 16 edges after start is sampled
    q.push_back('{cyc + 17, 1'b1, 4'b0000});
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("nominal ab step", {gate_a, gate_b}, i);
      check("nominal busy", busy, 1);
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    check("nominal busy after", busy, 0);
    check("nominal ab after", {gate_a, gate_b}, 0);
    check("nominal pass held", pass, 1);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check("nominal rd_data", rd_data, golden[i]);
    end

    // XOR output stuck at 0
    fault = 7'h10;
    q.push_back('{cyc + 17, 1'b0, 4'b0110});
    pulse_start();
    repeat (17) @(negedge clk);
    check("fault err_mask held", err_mask, 4'b0110);
    check("fault pass held", pass, 0);
    rd_idx = 2'd1; #1;
    check("fault rd_data 1", rd_data, 7'h46);
    rd_idx = 2'd2; #1;
    check("fault rd_data 2", rd_data, 7'h06);
    fault = 7'h00;

    // Zero-settle build, done 8 edges after start
    q0.push_back('{cyc + 9, 1'b1, 4'b0000});
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("zero settle ab step", {gate_a0, gate_b0}, 1);
    repeat (7) @(negedge clk);
    check("zero settle busy after", busy0, 0);

    // Abort while {a,b}=10
    pulse_start();
    repeat (8) @(negedge clk);
    check("abort ab before", {gate_a, gate_b}, 2'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort ab", {gate_a, gate_b}, 0);
    check("abort pass", pass, 0);
    check("abort err_mask", err_mask, 0);
    rd_idx = 2'd0; #1;
    check("abort rd_data 0", rd_data, 7'h6C);
    rd_idx = 2'd1; #1;
    check("abort rd_data 1", rd_data, 7'h56);
    rd_idx = 2'd2; #1;
    check("abort rd_data 2 kept", rd_data, 7'h06);
    repeat (20) @(negedge clk);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort idle busy", busy, 0);

    // Start held through a whole sweep, then a re-start
    fault = 7'h10;
    q.push_back('{cyc + 17, 1'b0, 4'b0110});
    start = 1'b1;
    repeat (17) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("held start busy after", busy, 0);
    repeat (3) @(negedge clk);
    check("held start still idle", busy, 0);
    fault = 7'h00;
    q.push_back('{cyc + 17, 1'b1, 4'b0000});
    pulse_start();
    check("restart err_mask cleared", err_mask, 0);
    repeat (17) @(negedge clk);
    check("restart pass", pass, 1);

    // Asynchronous reset while waiting on vector 1
    pulse_start();
    repeat (5) @(negedge clk);
    check("pre-reset ab", {gate_a, gate_b}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    rd_idx = 2'd0; #0;
    check("async reset busy", busy, 0);
    check("async reset ab", {gate_a, gate_b}, 0);
    check("async reset done", done, 0);
    check("async reset pass", pass, 0);
    check("async reset err_mask", err_mask, 0);
    check("async reset rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-reset busy", busy, 0);

    check("dut expectations drained", q.size(), 0);
    check("dut0 expectations drained", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
